// File: rtl/dm_store_buffer.sv
// Posted-store FIFO between the memory stage and data memory.
// Stores are queued and retired oldest-first, one per cycle when drain_en allows.
// Loads that hit a pending store's word are stalled until that store retires.
module dm_store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic             st_byte,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [31:0]      st_pc,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  output logic             ld_stall,
  input  logic             drain_en,
  output logic             dm_MemWrite,
  output logic             dm_sb_sel,
  output logic [31:0]      dm_Addr,
  output logic [31:0]      dm_Din,
  output logic [31:0]      dm_Pc,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

  logic             byte_q [DEPTH];
  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      pc_q   [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W:0]   count_q;

  logic push, pop, hit;

  // Handshake and drain qualifiers; both suppressed while reset is held low.
  always_comb begin
    empty    = (count_q == '0);
    count    = count_q;
    st_ready = reset && (count_q != FullCount);
    push     = st_valid && st_ready;
    pop      = reset && drain_en && !empty;
  end

  // DM port is driven straight from the head entry; zeroed when nothing is pending.
  always_comb begin
    dm_MemWrite = pop;
    dm_sb_sel   = 1'b0;
    dm_Addr     = '0;
    dm_Din      = '0;
    dm_Pc       = '0;
    if (!empty) begin
      dm_sb_sel = byte_q[head_q];
      dm_Addr   = addr_q[head_q];
      dm_Din    = data_q[head_q];
      dm_Pc     = pc_q[head_q];
    end
  end

  // Word-granular hazard check against every pending entry; the incoming store is excluded.
  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[PTR_W'(i)] && (addr_q[PTR_W'(i)][31:2] == ld_addr[31:2])) begin
        hit = 1'b1;
      end
    end
    ld_stall = reset && ld_valid && hit;
  end

  // Pointer, count and entry storage; reset discards any pending or in-flight store.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (push) begin
        byte_q[tail_q]  <= st_byte;
        addr_q[tail_q]  <= st_addr;
        data_q[tail_q]  <= st_data;
        pc_q[tail_q]    <= st_pc;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_W'(1);
      end
      // head and tail only coincide when empty or full, so push and pop never share a slot
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Self-checking bench: driver with a queue-based reference model, plus a DM-side
// monitor that pops expected writes from a scoreboard whenever a write is presented.
module tb_dm_store_buffer;

  logic        clk;
  logic        reset;
  logic        st_valid, st_byte;
  logic        st_ready;
  logic [31:0] st_addr, st_data, st_pc;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_stall;
  logic        drain_en;
  logic        dm_MemWrite, dm_sb_sel;
  logic [31:0] dm_Addr, dm_Din, dm_Pc;
  logic        empty;
  logic [2:0]  count;

  dm_store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_byte     (st_byte),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_pc       (st_pc),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_stall    (ld_stall),
    .drain_en    (drain_en),
    .dm_MemWrite (dm_MemWrite),
    .dm_sb_sel   (dm_sb_sel),
    .dm_Addr     (dm_Addr),
    .dm_Din      (dm_Din),
    .dm_Pc       (dm_Pc),
    .empty       (empty),
    .count       (count)
  );

  typedef struct {
    logic        b;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] p;
  } ent_t;

  ent_t mq[$];     // reference contents of the buffer, oldest first
  ent_t exp_q[$];  // scoreboard of DM writes still owed by the DUT

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h required %h", name, $time, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check combinational/registered outputs, advance the model.
  task automatic cycle(input logic rst, input logic sv, input logic sb, input logic [31:0] sa,
                       input logic [31:0] sd, input logic [31:0] sp, input logic lv,
                       input logic [31:0] la, input logic de);
    logic exp_ready, exp_pop, exp_stall, acc;
    ent_t e;
    @(posedge clk);
    #1;
    reset = rst; st_valid = sv; st_byte = sb; st_addr = sa; st_data = sd; st_pc = sp;
    ld_valid = lv; ld_addr = la; drain_en = de;
    exp_ready = rst && (mq.size() < 4);
    exp_pop   = rst && de && (mq.size() > 0);
    exp_stall = 1'b0;
    foreach (mq[i]) if (mq[i].a[31:2] == la[31:2]) exp_stall = 1'b1;
    exp_stall = exp_stall && rst && lv;
    acc = sv && exp_ready;
    #3;
    chk("count", 32'(count), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("st_ready", 32'(st_ready), 32'(exp_ready));
    chk("ld_stall", 32'(ld_stall), 32'(exp_stall));
    chk("dm_MemWrite", 32'(dm_MemWrite), 32'(exp_pop));
    if (mq.size() == 0) chk("dm_Addr_idle", dm_Addr, 32'h0);
    if (!rst) begin
      mq.delete();
      exp_q.delete();
    end else begin
      if (exp_pop) void'(mq.pop_front());
      if (acc) begin
        e.b = sb; e.a = sa; e.d = sd; e.p = sp;
        mq.push_back(e);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic idle(input logic de);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, de);
  endtask

  task automatic st(input logic sb, input logic [31:0] a, input logic [31:0] d, input logic de);
    cycle(1'b1, 1'b1, sb, a, d, 32'h1000 + a, 1'b0, 32'h0, de);
  endtask

  task automatic ld(input logic [31:0] a, input logic de);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, a, de);
  endtask

  // DM-side monitor: every presented write must match the oldest owed store.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (dm_MemWrite === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL dm_unexpected @%0t: got write to %h required no write", $time, dm_Addr);
        end else begin
          e = exp_q.pop_front();
          chk("dm_Addr", dm_Addr, e.a);
          chk("dm_Pc", dm_Pc, e.p);
          chk("dm_sb_sel", 32'(dm_sb_sel), 32'(e.b));
          if (e.b) chk("dm_Din_byte", {24'h0, dm_Din[7:0]}, {24'h0, e.d[7:0]});
          else     chk("dm_Din", dm_Din, e.d);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; st_valid = 1'b0; st_byte = 1'b0; st_addr = '0; st_data = '0; st_pc = '0;
    ld_valid = 1'b0; ld_addr = '0; drain_en = 1'b0;

    // Reset, then a single word store drained straight away.
    cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 32'h3, 32'hfabc1234, 32'h00003000, 1'b0, 0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Fill with drain held off, attempt a fifth push, then drain.
    st(1'b0, 32'h0, 32'hA0, 1'b0);
    st(1'b0, 32'h4, 32'hA4, 1'b0);
    st(1'b0, 32'h8, 32'hA8, 1'b0);
    st(1'b0, 32'hC, 32'hAC, 1'b0);
    st(1'b0, 32'h10, 32'hEE, 1'b0);
    st(1'b0, 32'h10, 32'hEE, 1'b1);  // full: ignored even though a pop happens
    repeat (5) idle(1'b1);

    // Load hazard against a pending byte store.
    st(1'b1, 32'h11, 32'hAB, 1'b0);
    ld(32'h13, 1'b0);
    ld(32'h14, 1'b0);
    ld(32'h13, 1'b1);
    ld(32'h13, 1'b1);

    // Simultaneous push/pop at count 2, then a long stream across the pointer wrap.
    st(1'b0, 32'h40, 32'h1, 1'b0);
    st(1'b0, 32'h44, 32'h2, 1'b0);
    st(1'b0, 32'h48, 32'h3, 1'b1);
    st(1'b0, 32'h4C, 32'h4, 1'b1);
    repeat (3) idle(1'b1);
    for (int i = 0; i < 10; i++) st(1'b0, 32'h100 + 32'(i) * 4, $urandom, 1'b1);
    repeat (3) idle(1'b1);

    // Reset with three entries pending: old entries must never reach DM.
    st(1'b0, 32'h200, 32'h5, 1'b0);
    st(1'b0, 32'h204, 32'h6, 1'b0);
    st(1'b0, 32'h208, 32'h7, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1, 32'h200, 1'b1);
    repeat (3) idle(1'b1);

    // Same-address stores retire in issue order.
    st(1'b0, 32'h20, 32'h11111111, 1'b0);
    st(1'b0, 32'h20, 32'h22222222, 1'b0);
    repeat (3) idle(1'b1);

    // Random traffic; small address window to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0), 1'(($urandom) & 1),
            32'($urandom_range(0, 63)), $urandom, $urandom, 1'(($urandom) & 1),
            32'($urandom_range(0, 63)), ($urandom_range(0, 2) != 0));
    end
    repeat (6) idle(1'b1);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drained: got %0d owed writes required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
